// File: rtl/frame_binarizer_12x12.sv
`default_nettype none
// ============================================================================
//  Module   : frame_binarizer_12x12
//  Purpose  : Turns a raster luma pixel stream into a 12x12 binary image.
//             A centred 12*CELL square window is cut into 12x12 cells. The
//             dark ("ink") pixels in each cell are counted, and each count
//             is thresholded to one bit. The 144-bit result is published
//             atomically once for each frame armed by a start pulse.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             start         - arms capture of the next full frame
//             sof, eol      - start-of-frame / end-of-line pulses
//             pix_valid     - qualifies pix_y
//             pix_y[7:0]    - luma sample
//             busy          - capture armed or in progress
//             img[143:0]    - row-major image, bit 143 = cell (0,0)
//             img_valid     - one-cycle pulse when img is updated
//  Revision : 1.0 - initial release
// ============================================================================
module frame_binarizer_12x12 #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int CELL       = 20,
    parameter int X0         = 200,
    parameter int Y0         = 120,
    parameter int PIX_THRESH = 80,
    parameter int INVERT     = 1,
    parameter int MIN_COUNT  = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sof,
    input  logic         eol,
    input  logic         pix_valid,
    input  logic [7:0]   pix_y,
    output logic         busy,
    output logic [143:0] img,
    output logic         img_valid
);

    localparam int c_NCELL = 12;
    localparam int c_XW    = $clog2(IMG_W + 1);
    localparam int c_YW    = $clog2(IMG_H + 1);
    localparam int c_SW    = $clog2(CELL + 1);
    localparam int c_CW    = $clog2(CELL * CELL + 1);

    localparam logic [c_XW-1:0] c_IMG_W    = c_XW'(IMG_W);
    localparam logic [c_XW-1:0] c_X0       = c_XW'(X0);
    localparam logic [c_XW-1:0] c_X1       = c_XW'(X0 + c_NCELL * CELL);
    localparam logic [c_YW-1:0] c_IMG_H    = c_YW'(IMG_H);
    localparam logic [c_YW-1:0] c_Y0       = c_YW'(Y0);
    localparam logic [c_YW-1:0] c_Y1       = c_YW'(Y0 + c_NCELL * CELL);
    localparam logic [c_SW-1:0] c_SUB_LAST = c_SW'(CELL - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(CELL * CELL);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CAPTURE  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_XW-1:0]     x_q, x_d;
    logic [c_YW-1:0]     y_q, y_d;
    logic [3:0]          col_q, col_d;     // cell column of the current pixel
    logic [c_SW-1:0]     csub_q, csub_d;   // pixel offset inside that column
    logic [3:0]          row_q, row_d;     // cell row of the current line
    logic [c_SW-1:0]     rsub_q, rsub_d;   // line offset inside that row
    logic [143:0]        shadow_q, shadow_d;
    logic [143:0]        img_q, img_d;

    logic                w_x_ok, w_y_ok, w_in_x, w_in_y;
    logic                w_capt, w_ink, w_ink_px;
    logic                w_row_end, w_complete;
    logic [c_NCELL-1:0]  w_row_bits;

    // Positions past the active area saturate, so they never alias back
    // into the window.
    assign w_x_ok     = (x_q < c_IMG_W);
    assign w_y_ok     = (y_q < c_IMG_H);
    assign w_in_x     = w_x_ok && (x_q >= c_X0) && (x_q < c_X1);
    assign w_in_y     = w_y_ok && (y_q >= c_Y0) && (y_q < c_Y1);
    assign w_capt     = (state_q == S_CAPTURE);
    assign w_ink      = (INVERT != 0) ? (int'(pix_y) <  PIX_THRESH)
                                      : (int'(pix_y) >= PIX_THRESH);
    assign w_ink_px   = w_capt && pix_valid && w_in_x && w_in_y && w_ink;
    assign w_row_end  = eol && w_in_y && (rsub_q == c_SUB_LAST);
    assign w_complete = w_capt && w_row_end && (row_q == 4'd11);

    // One saturating ink counter per cell column. Each counter is reused
    // for every cell row and is cleared when its row is written out.
    for (genvar c = 0; c < c_NCELL; c++) begin : g_cell
        logic [c_CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (sof || w_row_end) begin
                cnt_d = '0;
            end else if (w_ink_px && (col_q == 4'(c)) && (cnt_q != c_CNT_MAX)) begin
                cnt_d = cnt_q + c_CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Column 0 is the MSB of the row slice, which makes bit 143 the
        // top-left cell.
        assign w_row_bits[c_NCELL-1-c] = (int'(cnt_q) >= MIN_COUNT);
    end

    // Position tracking, shadow image and output image.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        csub_d   = csub_q;
        row_d    = row_q;
        rsub_d   = rsub_q;
        shadow_d = shadow_q;
        img_d    = img_q;

        if (sof) begin
            x_d    = '0;
            y_d    = '0;
            col_d  = '0;
            csub_d = '0;
            row_d  = '0;
            rsub_d = '0;
        end else if (eol) begin
            x_d    = '0;
            col_d  = '0;
            csub_d = '0;
            if (w_y_ok) begin
                y_d = y_q + c_YW'(1);
            end
            if (w_in_y) begin
                if (rsub_q == c_SUB_LAST) begin
                    rsub_d = '0;
                    row_d  = row_q + 4'd1;
                end else begin
                    rsub_d = rsub_q + c_SW'(1);
                end
            end
        end else if (pix_valid) begin
            if (w_x_ok) begin
                x_d = x_q + c_XW'(1);
            end
            if (w_in_x) begin
                if (csub_q == c_SUB_LAST) begin
                    csub_d = '0;
                    col_d  = col_q + 4'd1;
                end else begin
                    csub_d = csub_q + c_SW'(1);
                end
            end
        end

        if (sof) begin
            shadow_d = '0;
        end else if (w_capt && w_row_end) begin
            for (int r = 0; r < c_NCELL; r++) begin
                if (row_q == 4'(r)) begin
                    shadow_d[(c_NCELL-1-r)*c_NCELL +: c_NCELL] = w_row_bits;
                end
            end
        end

        // The image register is loaded from the shadow with the final row
        // already merged in. This makes the new image visible during the
        // DONE cycle, together with img_valid.
        if (w_complete) begin
            img_d = shadow_d;
        end
    end

    // Frame-level sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_WAIT_SOF;
            S_WAIT_SOF: if (sof)   state_d = S_CAPTURE;
            // A repeated sof restarts the capture: the counters, the
            // position and the shadow are all cleared by sof itself.
            S_CAPTURE:  if (w_complete) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            csub_q   <= '0;
            row_q    <= '0;
            rsub_q   <= '0;
            shadow_q <= '0;
            img_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            csub_q   <= csub_d;
            row_q    <= row_d;
            rsub_q   <= rsub_d;
            shadow_q <= shadow_d;
            img_q    <= img_d;
        end
    end

    assign busy      = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE);
    assign img_valid = (state_q == S_DONE);
    assign img       = img_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_binarizer_12x12.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_binarizer_12x12
//  Purpose  : Self-checking bench for frame_binarizer_12x12. It uses a
//             reduced geometry (64x60 frame, 4x4 cells, window at x 10..57,
//             y 6..53, threshold 10 of 16) so that full frames stay short.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_binarizer_12x12;

    localparam int IMG_W      = 64;
    localparam int IMG_H      = 60;
    localparam int CELL       = 4;
    localparam int X0         = 10;
    localparam int Y0         = 6;
    localparam int PIX_THRESH = 80;
    localparam int INVERT     = 1;
    localparam int MIN_COUNT  = 10;
    localparam int LAST_LINE  = Y0 + 12 * CELL - 1;   // 53
    localparam int N_LINES    = 56;

    localparam logic [143:0] E_ZERO = 144'd0;
    localparam logic [143:0] E_ONES = {144{1'b1}};
    localparam logic [143:0] E_TL   = {1'b1, 143'd0};
    localparam logic [143:0] E_BR   = 144'd1;
    localparam logic [143:0] E_C55  = 144'd1 << 78;

    logic         clk = 1'b0;
    logic         rst, start, sof, eol, pix_valid;
    logic [7:0]   pix_y;
    logic         busy, img_valid;
    logic [143:0] img;

    frame_binarizer_12x12 #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CELL(CELL), .X0(X0), .Y0(Y0),
        .PIX_THRESH(PIX_THRESH), .INVERT(INVERT), .MIN_COUNT(MIN_COUNT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sof(sof), .eol(eol),
        .pix_valid(pix_valid), .pix_y(pix_y), .busy(busy), .img(img),
        .img_valid(img_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vcount = 0;
    int   valid_cyc = -1;
    logic busy_at_valid = 1'b1;
    always @(negedge clk) begin
        if (img_valid === 1'b1) begin
            vcount++;
            valid_cyc     = cyc;
            busy_at_valid = busy;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int eol_cyc = -100;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Test pictures: 0 white, 1 black, 2 dark top-left cell, 3 dark
    // bottom-right cell, 4 cell (5,5) holding ndark dark pixels, the last
    // of which has luma lastv.
    function automatic logic [7:0] pval(int mode, int x, int y, int ndark, int lastv);
        int k;
        case (mode)
            0: return 8'd255;
            1: return 8'd0;
            2: return (x >= 10 && x < 14 && y >= 6 && y < 10) ? 8'd0 : 8'd255;
            3: return (x >= 54 && x < 58 && y >= 50 && y < 54) ? 8'd0 : 8'd255;
            default: begin
                if (x >= 30 && x < 34 && y >= 26 && y < 30) begin
                    k = (y - 26) * 4 + (x - 30);
                    if (k < ndark - 1) return 8'd0;
                    if (k == ndark - 1) return 8'(lastv);
                end
                return 8'd255;
            end
        endcase
    endfunction

    task automatic drive_frame(input int mode, input int nlines, input int ndark, input int lastv);
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                pix_valid = 1'b1;
                pix_y     = pval(mode, x, y, ndark, lastv);
                @(negedge clk);
            end
            pix_valid = 1'b0;
            eol       = 1'b1;
            if (y == LAST_LINE) eol_cyc = cyc;
            @(negedge clk);
            eol = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    typedef struct {
        string        name;
        int           mode;
        int           ndark;
        int           lastv;
        logic [143:0] exp_img;
    } vec_t;

    vec_t vecs[8];
    int   v0;

    initial begin
        vecs[0] = '{"white",      0, 0,  0,  E_ZERO};
        vecs[1] = '{"black",      1, 0,  0,  E_ONES};
        vecs[2] = '{"top_left",   2, 0,  0,  E_TL};
        vecs[3] = '{"bot_right",  3, 0,  0,  E_BR};
        vecs[4] = '{"c55_n10",    4, 10, 0,  E_C55};
        vecs[5] = '{"c55_n9",     4, 9,  0,  E_ZERO};
        vecs[6] = '{"c55_pix79",  4, 10, 79, E_C55};
        vecs[7] = '{"c55_pix80",  4, 10, 80, E_ZERO};

        rst = 1'b1; start = 1'b0; sof = 1'b0; eol = 1'b0;
        pix_valid = 1'b0; pix_y = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",  144'(busy), 144'd0);
        check("reset_valid", 144'(img_valid), 144'd0);
        check("reset_img",   img, E_ZERO);
        rst = 1'b0;

        // First frame: check pulse timing and that busy falls with img_valid.
        pulse_start();
        check("busy_after_start", 144'(busy), 144'd1);
        v0 = vcount;
        drive_frame(0, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("first_pulses",     144'(vcount - v0), 144'd1);
        check("first_latency",    144'(valid_cyc - eol_cyc), 144'd1);
        check("busy_at_valid",    144'(busy_at_valid), 144'd0);
        check("first_img",        img, E_ZERO);
        check("first_busy_after", 144'(busy), 144'd0);

        // Without a new start, a frame must be ignored.
        v0 = vcount;
        drive_frame(1, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("nostart_pulses", 144'(vcount - v0), 144'd0);
        check("nostart_img",    img, E_ZERO);

        for (int i = 0; i < 8; i++) begin
            pulse_start();
            v0 = vcount;
            drive_frame(vecs[i].mode, N_LINES, vecs[i].ndark, vecs[i].lastv);
            repeat (4) @(negedge clk);
            check({vecs[i].name, "_pulses"}, 144'(vcount - v0), 144'd1);
            check({vecs[i].name, "_img"},    img, vecs[i].exp_img);
        end

        // Short frame (7 cell rows) and then a full black frame.
        pulse_start();
        v0 = vcount;
        drive_frame(1, Y0 + 7 * CELL, 0, 0);
        check("abort_pulses", 144'(vcount - v0), 144'd0);
        check("abort_img",    img, E_ZERO);
        check("abort_busy",   144'(busy), 144'd1);
        drive_frame(1, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("restart_pulses", 144'(vcount - v0), 144'd1);
        check("restart_img",    img, E_ONES);

        // Reset while a capture is running.
        pulse_start();
        drive_frame(1, 20, 0, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rst_busy",  144'(busy), 144'd0);
        check("rst_img",   img, E_ZERO);
        check("rst_valid", 144'(img_valid), 144'd0);
        v0 = vcount;
        drive_frame(1, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("post_rst_pulses", 144'(vcount - v0), 144'd0);
        check("post_rst_img",    img, E_ZERO);

        // A start while busy is ignored.
        pulse_start();
        v0 = vcount;
        drive_frame(1, 20, 0, 0);
        pulse_start();
        check("start_busy_busy", 144'(busy), 144'd1);
        drive_frame(1, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("start_busy_pulses", 144'(vcount - v0), 144'd1);
        check("start_busy_img",    img, E_ONES);
        check("start_busy_idle",   144'(busy), 144'd0);
        v0 = vcount;
        drive_frame(0, N_LINES, 0, 0);
        repeat (4) @(negedge clk);
        check("final_pulses", 144'(vcount - v0), 144'd0);
        check("final_img",    img, E_ONES);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
